// File: rtl/seg_display_arbiter_if.sv
// Display arbiter bus: client requests, blink enables and digit data in;
// registered segment patterns and grant status out.
interface seg_display_arbiter_if;
    logic [2:0] req;
    logic [2:0] blink;
    logic [7:0] digits_0;
    logic [7:0] digits_1;
    logic [7:0] digits_2;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [2:0] gnt;
    logic       active;

    modport master (
        output req, blink, digits_0, digits_1, digits_2,
        input  seg1, seg2, gnt, active
    );

    modport slave (
        input  req, blink, digits_0, digits_1, digits_2,
        output seg1, seg2, gnt, active
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Shares two 7-segment digits among three clients: fixed priority
// (highest index wins), minimum hold before preemption, per-client blink.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 1_200_000,
    parameter int BLINK_HALF  = 3_000_000
) (
    input logic                  clk,
    input logic                  rst,
    seg_display_arbiter_if.slave bus
);
    localparam int HW_RAW = $clog2(HOLD_CYCLES + 1);
    localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam int BW_RAW = $clog2(BLINK_HALF);
    localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;

    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST =
        (HOLD_CYCLES > 1) ? HW'(HOLD_CYCLES - 1) : '0;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;

    state_t          state, state_n, enter;
    logic [2:0]      gnt, gnt_n, hi_mask;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [BW-1:0]   blink_cnt, blink_n;
    logic            phase, phase_n;
    logic            new_grant, blank;
    logic [7:0]      seg1, seg2, seg1_n, seg2_n, data;

    function automatic logic [2:0] top_one(input logic [2:0] r);
        if (r[2])      return 3'b100;
        else if (r[1]) return 3'b010;
        else if (r[0]) return 3'b001;
        else           return 3'b000;
    endfunction

    function automatic logic [7:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // A hold of one cycle or less is already satisfied on the grant edge.
    assign enter   = (HOLD_CYCLES <= 1) ? OWN : HOLD;
    assign hi_mask = {gnt[1] | gnt[0], gnt[0], 1'b0};

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        new_grant = 1'b0;
        hold_n    = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        case (state)
            IDLE: begin
                hold_n = '0;
                gnt_n  = 3'b000;
                if (|bus.req) begin
                    gnt_n     = top_one(bus.req);
                    state_n   = enter;
                    new_grant = 1'b1;
                end
            end
            HOLD, OWN: begin
                if (!(|(bus.req & gnt))) begin
                    hold_n = '0;
                    if (|bus.req) begin
                        gnt_n     = top_one(bus.req);
                        state_n   = enter;
                        new_grant = 1'b1;
                    end else begin
                        gnt_n   = 3'b000;
                        state_n = IDLE;
                    end
                end else if (state == HOLD) begin
                    if (hold_n == HOLD_LAST) state_n = OWN;
                end else if (|(bus.req & hi_mask)) begin
                    gnt_n     = top_one(bus.req);
                    state_n   = enter;
                    hold_n    = '0;
                    new_grant = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 3'b000;
                hold_n  = '0;
            end
        endcase
    end

    always_comb begin
        blink_n = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        phase_n = (blink_cnt == BLINK_LAST) ? ~phase : phase;
        if (new_grant) begin
            blink_n = '0;
            phase_n = 1'b1;
        end
    end

    always_comb begin
        data = 8'h00;
        unique case (1'b1)
            gnt_n[0]: data = bus.digits_0;
            gnt_n[1]: data = bus.digits_1;
            gnt_n[2]: data = bus.digits_2;
            default:  data = 8'h00;
        endcase
        blank  = ~(|gnt_n) | ((|(bus.blink & gnt_n)) & ~phase_n);
        seg1_n = blank ? 8'h00 : decode(data[7:4]);
        seg2_n = blank ? 8'h00 : decode(data[3:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 3'b000;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            seg1      <= 8'h00;
            seg2      <= 8'h00;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            hold_cnt  <= hold_n;
            blink_cnt <= blink_n;
            phase     <= phase_n;
            seg1      <= seg1_n;
            seg2      <= seg2_n;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.active = |gnt;
    assign bus.seg1   = seg1;
    assign bus.seg2   = seg2;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter against a grant-age reference
// model, plus directed scenarios for hold, switch, blink, blank and reset.
module tb_seg_display_arbiter;
    localparam int HOLD  = 4;
    localparam int BLINK = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Model: current grantee (-1 = none) and cycles since that grant.
    int   m_g;
    int   m_age;
    logic [7:0] m_seg1;
    logic [7:0] m_seg2;
    logic [7:0] seg_tab [16];

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (BLINK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hi(input logic [2:0] r);
        for (int i = 2; i >= 0; i--)
            if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] pick(input int g);
        case (g)
            0:       return bus.digits_0;
            1:       return bus.digits_1;
            default: return bus.digits_2;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] d;
        int k;
        if (m_g < 0) begin
            if (bus.req != 0) begin
                m_g   = hi(bus.req);
                m_age = 0;
            end
        end else if (!bus.req[m_g]) begin
            m_g   = hi(bus.req);
            m_age = 0;
        end else begin
            k = m_age + 1;
            if (k >= HOLD && hi(bus.req) > m_g) begin
                m_g   = hi(bus.req);
                m_age = 0;
            end else begin
                m_age = k;
            end
        end
        m_seg1 = 8'h00;
        m_seg2 = 8'h00;
        if (m_g >= 0) begin
            d = pick(m_g);
            if (!(bus.blink[m_g] && ((m_age / BLINK) % 2 == 1))) begin
                m_seg1 = seg_tab[d[7:4]];
                m_seg2 = seg_tab[d[3:0]];
            end
        end
    endtask

    task automatic compare_all();
        logic [2:0] eg;
        eg = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("active", 32'(bus.active), 32'(m_g >= 0));
        check("seg1", 32'(bus.seg1), 32'(m_seg1));
        check("seg2", 32'(bus.seg2), 32'(m_seg2));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_g    = -1;
            m_seg1 = 8'h00;
            m_seg2 = 8'h00;
        end else begin
            model_edge();
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.req      = 3'b000;
        bus.blink    = 3'b000;
        bus.digits_0 = 8'h00;
        bus.digits_1 = 8'h00;
        bus.digits_2 = 8'h00;
        m_g          = -1;
        m_age        = 0;
        m_seg1       = 8'h00;
        m_seg2       = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] t [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        for (int i = 0; i < 16; i++)
            seg_tab[i] = (i < 10) ? t[i] : 8'h00;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        m_g    = -1;
        m_age  = 0;
        bus.req = 3'b000;
        bus.blink = 3'b000;
        bus.digits_0 = 8'h00;
        bus.digits_1 = 8'h00;
        bus.digits_2 = 8'h00;
        #12;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_act", 32'(bus.active), 32'h0);
        check("rst_seg1", 32'(bus.seg1), 32'h0);
        check("rst_seg2", 32'(bus.seg2), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Grant, then a higher request arriving during the hold window
        bus.req      = 3'b001;
        bus.digits_0 = 8'h27;
        step();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_seg1", 32'(bus.seg1), 32'h5B);
        check("t1_seg2", 32'(bus.seg2), 32'h07);
        check("t1_act", 32'(bus.active), 32'h1);
        bus.digits_2 = 8'h99;
        bus.req      = 3'b101;
        for (int i = 1; i < HOLD; i++) begin
            step();
            check("t2_held", 32'(bus.gnt), 32'h1);
        end
        step();
        check("t2_gnt", 32'(bus.gnt), 32'h4);
        check("t2_seg1", 32'(bus.seg1), 32'h6F);
        check("t2_seg2", 32'(bus.seg2), 32'h6F);

        // Simultaneous rise, then release falls back to the lower client
        do_reset();
        bus.req = 3'b101;
        step();
        check("t3_gnt", 32'(bus.gnt), 32'h4);
        bus.req = 3'b001;
        step();
        check("t3_back", 32'(bus.gnt), 32'h1);
        bus.req = 3'b011;
        step();
        check("t3_restart", 32'(bus.gnt), 32'h1);

        // Blink on client 1
        do_reset();
        bus.req      = 3'b010;
        bus.blink    = 3'b010;
        bus.digits_1 = 8'h30;
        for (int i = 0; i < 12; i++) begin
            step();
            check("t4_seg1", 32'(bus.seg1),
                  ((i / BLINK) % 2 == 0) ? 32'h4F : 32'h0);
            check("t4_gnt", 32'(bus.gnt), 32'h2);
        end

        // Out-of-range digits blank; dropping all requests idles
        do_reset();
        bus.req      = 3'b001;
        bus.digits_0 = 8'hAF;
        step();
        check("t5_seg1", 32'(bus.seg1), 32'h0);
        check("t5_seg2", 32'(bus.seg2), 32'h0);
        bus.req = 3'b000;
        step();
        check("t5_gnt", 32'(bus.gnt), 32'h0);
        check("t5_act", 32'(bus.active), 32'h0);

        // Asynchronous reset in the middle of a hold
        do_reset();
        bus.req      = 3'b001;
        bus.digits_0 = 8'h55;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        check("t6_gnt", 32'(bus.gnt), 32'h0);
        check("t6_act", 32'(bus.active), 32'h0);
        check("t6_seg1", 32'(bus.seg1), 32'h0);
        check("t6_seg2", 32'(bus.seg2), 32'h0);
        m_g    = -1;
        m_seg1 = 8'h00;
        m_seg2 = 8'h00;
        @(negedge clk);
        bus.req = 3'b010;
        rst     = 1'b0;
        step();
        check("t6_gnt2", 32'(bus.gnt), 32'h2);

        // Random traffic: slowly changing requests, live digit data
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) bus.req = 3'($urandom);
            if ($urandom_range(9) == 0) bus.blink = 3'($urandom);
            bus.digits_0 = 8'($urandom);
            bus.digits_1 = 8'($urandom);
            bus.digits_2 = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
